noc_packet_parser: RTL
======================

Name: noc_packet_parser

Overview:
- Receive-side counterpart of the packet creator: accepts NoC flits from the router ejection port and rebuilds a 1-byte-wide AXI-Stream message.
- Recovers TDEST and source ID from the header flit and TID from the flit VC.
- Removes padding bytes.
- Holds back one byte so that TLAST can be attached correctly even when a packet ends with an all-padding tail.

Parameters:
- AxisDataWidth, 8, output TDATA width; only 8 supported.
- NocDataWidth, 64, flit width; only 64 supported.
- flitTypeSize, 2, flit type field width.
- NocVirtualChannelIdWidth, 3, VC id width.
- NocBroadcastWidth, 1, broadcast flag width.
- TIdWidth, 8, output TID width; VC id zero-extended into it.
- TDestWidth, 11, node id width for destination and source fields.

Ports:
- m_axis_aclk  in  1  single clock.
- m_axis_arstn  in  1  reset, asynchronous, active-low.
- network_flit_i  in  NocDataWidth  flit payload.
- network_flit_type_i  in  flitTypeSize  00 HEADER, 01 BODY, 10 TAIL, 11 HEADER_AND_TAIL.
- network_vc_i  in  NocVirtualChannelIdWidth  VC of the flit.
- network_broadcast_i  in  NocBroadcastWidth  ignored; no output effect.
- network_valid_i  in  1  flit valid.
- network_ready_o  out  1  flit accept.
- m_axis_tdata  out  8  message byte.
- m_axis_tvalid  out  1  byte valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  final byte of the message.
- m_axis_tid  out  TIdWidth  VC of the header flit.
- m_axis_tdest  out  TDestWidth  destination field of the header.
- m_axis_tuser  out  TDestWidth  source id field of the header.
- proto_err_o  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Flit formats (byte 0 at bits [7:0]):
  - HEADER / HEADER_AND_TAIL: [63:53] dest, [52:42] src, [41:36] reserved, [35:32] padd for payload bytes 0..3 (1 = empty), [31:0] four bytes.
  - BODY: eight valid bytes.
  - TAIL: [63] last, [62:56] padd for bytes 0..6, [55:0] seven bytes.
  - An empty tail has padd = 7'h7F.
- Handshake: a flit transfers when network_valid_i & network_ready_o; a byte transfers when m_axis_tvalid & m_axis_tready.
- Datapath:
  - Flit register (64 bits) with an 8-bit pending mask and an end flag.
  - Hold register: one byte plus a valid bit.
  - Each cycle the lowest pending byte moves into the hold register when the hold register is empty or is being emitted.
- Output gating: the hold register is presented on m_axis_tvalid only when it is known whether another byte follows, i.e. one of:
  - the mask is non-zero, giving tlast=0;
  - the mask is zero and the end flag is set, giving tlast=1.
- Packet ending in an empty tail: the held byte stalls until the tail flit is accepted, then goes out with tlast=1.
- network_ready_o = 1 when the pending mask is zero and the end flag is clear.
  - A flit is accepted at most once every (valid bytes) cycles.
  - Accept-to-first-byte latency is 2 cycles.
- FSM states:
  - WAIT_HEAD: accept HEADER, go to IN_PKT; accept HEADER_AND_TAIL, go to LAST_FLIT.
  - IN_PKT: BODY stays in IN_PKT; TAIL goes to LAST_FLIT.
  - LAST_FLIT: drain until the hold register emits tlast, then go to WAIT_HEAD.
- Sideband latching:
  - tid, tdest and tuser are latched on header accept.
  - They are stable for the whole message.
  - They must not change while m_axis_tvalid is asserted.
- Protocol errors (each pulses proto_err_o for 1 cycle):
  - BODY or TAIL received in WAIT_HEAD: flit consumed and dropped.
  - HEADER or HEADER_AND_TAIL received in IN_PKT: the current message is closed by emitting the held byte with tlast=1, or if no byte is held the new header is stalled until the hold register is empty. The new header is then processed normally.
- Header or header-and-tail with all four bytes padded: treated as an empty message; no bytes emitted, proto_err_o pulses.
- Reset (asynchronous, any time, including mid-packet): all outputs 0, masks and hold register cleared, FSM in WAIT_HEAD, any partial message discarded.

Optional Feature:
- Macro: NOC_PACKET_PARSER_STATS_EN.
- When defined:
  - Adds a 16-bit output pkt_cnt_o: wrapping count of messages completed (byte with tlast transferred).
  - Adds a 16-bit output err_cnt_o: saturating count of proto_err_o pulses.
  - Both counters reset to 0.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package noc_pkg holds:
  - flit type encodings;
  - header field bit positions (dest, src, padd);
  - tail padd position;
  - PayloadSizeHeader=4, PayloadSizeTail=7, PayloadSizeBody=8.
- One sub-module, noc_flit_byte_serializer: the flit register, pending mask, lowest-set-bit byte select and hold register with tlast lookahead.
- The top level contains the FSM, header latching and error detection.

Test Plan:
- HEADER_AND_TAIL, vc=2, dest=11'h005, src=11'h001, padd=4'b1100, data 0xBBAA -> bytes AA, BB; tlast on BB; tid=2, tdest=5, tuser=1.
- HEADER (4 bytes 00..03), BODY (04..0B), TAIL padd=7'h7C (0C, 0D) -> 14 bytes 00..0D in order; tlast only on 0D; network_ready_o low while draining.
- HEADER, BODY, empty TAIL (padd=7'h7F) -> 12 bytes; byte 0B held until the tail is accepted, then emitted with tlast=1.
- m_axis_tready toggled 1-0-1-0 during the previous scenario -> same byte sequence; no duplication or loss; sideband stable.
- BODY while in WAIT_HEAD -> proto_err_o one pulse, no output bytes; a following HEADER_AND_TAIL is parsed normally.
- m_axis_arstn asserted after 3 bytes of a 12-byte message -> all outputs 0 immediately; a new HEADER_AND_TAIL is parsed cleanly; with NOC_PACKET_PARSER_STATS_EN, pkt_cnt_o = 1.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC receive-side packet parser: flit type
// encodings, header/tail field positions, payload sizes, FSM state type.
package noc_pkg;

  typedef enum logic [1:0] {
    FLIT_HEADER          = 2'b00,
    FLIT_BODY            = 2'b01,
    FLIT_TAIL            = 2'b10,
    FLIT_HEADER_AND_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_WAIT_HEAD = 2'd0,
    ST_IN_PKT    = 2'd1,
    ST_LAST_FLIT = 2'd2
  } parser_state_e;

  localparam int HdrDestMsb  = 63;
  localparam int HdrDestLsb  = 53;
  localparam int HdrSrcMsb   = 52;
  localparam int HdrSrcLsb   = 42;
  localparam int HdrPaddMsb  = 35;
  localparam int HdrPaddLsb  = 32;
  localparam int TailPaddMsb = 62;
  localparam int TailPaddLsb = 56;

  localparam int PayloadSizeHeader = 4;
  localparam int PayloadSizeTail   = 7;
  localparam int PayloadSizeBody   = 8;

  function automatic logic is_header(input logic [1:0] t);
    return (t == FLIT_HEADER) || (t == FLIT_HEADER_AND_TAIL);
  endfunction

  // Pending-byte mask for a freshly accepted flit (padd bit 1 = empty byte).
  function automatic logic [7:0] flit_byte_mask(input logic [1:0] t,
                                                input logic [3:0] hdr_padd,
                                                input logic [6:0] tail_padd);
    logic [7:0] m;
    case (flit_type_e'(t))
      FLIT_HEADER, FLIT_HEADER_AND_TAIL: m = {{(8-PayloadSizeHeader){1'b0}}, ~hdr_padd};
      FLIT_BODY:                         m = {PayloadSizeBody{1'b1}};
      default:                           m = {{(8-PayloadSizeTail){1'b0}}, ~tail_padd};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/noc_packet_parser_noc_flit_byte_serializer.sv
// Flit-to-byte serializer: holds one flit with a pending-byte mask and an
// end-of-message flag, picks the lowest pending byte each cycle and keeps
// one byte in a hold register so tlast is known before the byte is shown.
module noc_flit_byte_serializer
  import noc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_flit,
  input  logic [7:0]  load_mask,
  input  logic        load_end,
  input  logic        close,
  input  logic        tready,
  output logic [7:0]  tdata,
  output logic        tvalid,
  output logic        tlast,
  output logic        ser_ready,
  output logic        ser_idle
);

  logic [63:0] flit_q;
  logic [7:0]  mask_q;
  logic        end_q;
  logic [7:0]  hold_q;
  logic        hold_vld_q;

  logic [7:0]  sel_onehot;
  logic [7:0]  sel_byte;
  logic        mask_nz;
  logic        emit;
  logic        move;

  // Lowest-set-bit select of the pending mask (scan high to low, last hit wins).
  always_comb begin
    sel_onehot = '0;
    sel_byte   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        sel_byte      = flit_q[i*8 +: 8];
      end
    end
  end

  // Held byte is only shown once we know whether another byte follows it.
  assign mask_nz   = |mask_q;
  assign tvalid    = hold_vld_q & (mask_nz | end_q);
  assign tlast     = hold_vld_q & ~mask_nz & end_q;
  assign tdata     = hold_q;
  assign emit      = tvalid & tready;
  assign move      = mask_nz & (~hold_vld_q | emit);
  assign ser_ready = ~mask_nz & ~end_q;
  assign ser_idle  = ser_ready & ~hold_vld_q;

  // Flit register, pending mask and end flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_q <= '0;
      mask_q <= '0;
      end_q  <= 1'b0;
    end else if (load) begin
      flit_q <= load_flit;
      mask_q <= load_mask;
      end_q  <= load_end;
    end else begin
      if (move) begin
        mask_q <= mask_q & ~sel_onehot;
      end
      // An end flag with nothing left to send (no pending, nothing held) is dropped.
      if (close) begin
        end_q <= 1'b1;
      end else if (emit && tlast) begin
        end_q <= 1'b0;
      end else if (!mask_nz && !hold_vld_q) begin
        end_q <= 1'b0;
      end
    end
  end

  // Hold register: refilled from the flit when empty or being emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (move) begin
      hold_q     <= sel_byte;
      hold_vld_q <= 1'b1;
    end else if (emit) begin
      hold_vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_packet_parser.sv
// NoC packet parser top: rebuilds a byte-wide AXI-Stream message from
// ejected flits. Holds the message FSM, header sideband latching and
// protocol error detection. Optional statistics counters are enabled by
// defining NOC_PACKET_PARSER_STATS_EN.
module noc_packet_parser
  import noc_pkg::*;
#(
  parameter int AxisDataWidth            = 8,
  parameter int NocDataWidth             = 64,
  parameter int flitTypeSize             = 2,
  parameter int NocVirtualChannelIdWidth = 3,
  parameter int NocBroadcastWidth        = 1,
  parameter int TIdWidth                 = 8,
  parameter int TDestWidth               = 11
) (
  input  logic                                m_axis_aclk,
  input  logic                                m_axis_arstn,
  input  logic [NocDataWidth-1:0]             network_flit_i,
  input  logic [flitTypeSize-1:0]             network_flit_type_i,
  input  logic [NocVirtualChannelIdWidth-1:0] network_vc_i,
  input  logic [NocBroadcastWidth-1:0]        network_broadcast_i,
  input  logic                                network_valid_i,
  output logic                                network_ready_o,
  output logic [AxisDataWidth-1:0]            m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [TIdWidth-1:0]                 m_axis_tid,
  output logic [TDestWidth-1:0]               m_axis_tdest,
  output logic [TDestWidth-1:0]               m_axis_tuser,
  output logic                                proto_err_o
`ifdef NOC_PACKET_PARSER_STATS_EN
  ,
  output logic [15:0]                         pkt_cnt_o,
  output logic [15:0]                         err_cnt_o
`endif
);

  // state        | meaning
  // WAIT_HEAD    | idle, expecting a HEADER or HEADER_AND_TAIL flit
  // IN_PKT       | header seen, accepting BODY flits until a TAIL
  // LAST_FLIT    | final flit loaded (or message force-closed), draining to tlast

  parser_state_e state_q, state_d;

  logic       hdr_type;
  logic       hdr_empty;
  logic       load_end;
  logic [7:0] load_mask;
  logic       ready_c;
  logic       flit_xfer;
  logic       ser_load;
  logic       ser_close;
  logic       err_d;
  logic       hdr_latch;
  logic       ser_ready;
  logic       ser_idle;
  logic       rdy_en_q;
  logic       byte_last_xfer;

  logic [TIdWidth-1:0]   tid_q;
  logic [TDestWidth-1:0] tdest_q;
  logic [TDestWidth-1:0] tuser_q;

  logic unused_broadcast;
  assign unused_broadcast = ^network_broadcast_i;

  assign hdr_type  = is_header(network_flit_type_i);
  assign hdr_empty = &network_flit_i[HdrPaddMsb:HdrPaddLsb];
  assign load_end  = (network_flit_type_i == FLIT_TAIL) ||
                     (network_flit_type_i == FLIT_HEADER_AND_TAIL);
  assign load_mask = flit_byte_mask(network_flit_type_i,
                                    network_flit_i[HdrPaddMsb:HdrPaddLsb],
                                    network_flit_i[TailPaddMsb:TailPaddLsb]);
  assign flit_xfer = network_valid_i & ready_c;
  assign byte_last_xfer = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  noc_flit_byte_serializer u_ser (
    .clk       (m_axis_aclk),
    .rst_n     (m_axis_arstn),
    .load      (ser_load),
    .load_flit (network_flit_i),
    .load_mask (load_mask),
    .load_end  (load_end),
    .close     (ser_close),
    .tready    (m_axis_tready),
    .tdata     (m_axis_tdata),
    .tvalid    (m_axis_tvalid),
    .tlast     (m_axis_tlast),
    .ser_ready (ser_ready),
    .ser_idle  (ser_idle)
  );

  // FSM state register.
  always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
    if (!m_axis_arstn) begin
      state_q <= ST_WAIT_HEAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_HEAD: begin
        if (flit_xfer && hdr_type && !hdr_empty) begin
          state_d = load_end ? ST_LAST_FLIT : ST_IN_PKT;
        end
      end
      ST_IN_PKT: begin
        if ((flit_xfer && network_flit_type_i == FLIT_TAIL) || ser_close) begin
          state_d = ST_LAST_FLIT;
        end
      end
      default: begin
        if (byte_last_xfer || ser_idle) begin
          state_d = ST_WAIT_HEAD;
        end
      end
    endcase
  end

  // FSM outputs: flit accept, serializer load/close, error detect.
  // A header arriving mid-packet is held off (ready low) while the current
  // message is force-closed; it is accepted normally from WAIT_HEAD.
  always_comb begin
    ready_c   = 1'b0;
    ser_load  = 1'b0;
    ser_close = 1'b0;
    err_d     = 1'b0;
    hdr_latch = 1'b0;
    case (state_q)
      ST_WAIT_HEAD: begin
        ready_c = rdy_en_q & ser_ready;
        if (network_valid_i && ready_c) begin
          if (!hdr_type || hdr_empty) begin
            err_d = 1'b1;
          end else begin
            ser_load  = 1'b1;
            hdr_latch = 1'b1;
          end
        end
      end
      ST_IN_PKT: begin
        ready_c = rdy_en_q & ser_ready & ~hdr_type;
        if (network_valid_i && ready_c) begin
          ser_load = 1'b1;
        end else if (network_valid_i && hdr_type && ser_ready && rdy_en_q) begin
          ser_close = 1'b1;
          err_d     = 1'b1;
        end
      end
      default: begin
        ready_c = 1'b0;
      end
    endcase
  end

  assign network_ready_o = ready_c;

  // Ready is held low through reset and the first cycle after it.
  always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
    if (!m_axis_arstn) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  // Header sideband latch and registered error pulse.
  always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
    if (!m_axis_arstn) begin
      tid_q       <= '0;
      tdest_q     <= '0;
      tuser_q     <= '0;
      proto_err_o <= 1'b0;
    end else begin
      proto_err_o <= err_d;
      if (hdr_latch) begin
        tid_q   <= TIdWidth'(network_vc_i);
        tdest_q <= network_flit_i[HdrDestMsb:HdrDestLsb];
        tuser_q <= network_flit_i[HdrSrcMsb:HdrSrcLsb];
      end
    end
  end

  assign m_axis_tid   = tid_q;
  assign m_axis_tdest = tdest_q;
  assign m_axis_tuser = tuser_q;

`ifdef NOC_PACKET_PARSER_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] err_cnt_q;

  // Completed-message counter (wraps) and error counter (saturates).
  always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
    if (!m_axis_arstn) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (byte_last_xfer) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if (proto_err_o && err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule
